// File: rtl/or_unit_arbiter_if.sv
// Request/operand/result bundle between four requesters and or_unit_arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface or_unit_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_bus;
  logic [4*WIDTH-1:0] b_bus;
  logic [3:0]         gnt;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   s;
  logic [1:0]         id;
  logic               valid;
  logic               busy;

  modport master (
    output req, a_bus, b_bus,
    input  gnt, ack, s, id, valid, busy
  );

  modport slave (
    input  req, a_bus, b_bus,
    output gnt, ack, s, id, valid, busy
  );
endinterface

// File: rtl/or_unit_arbiter.sv
// Four-requester arbiter feeding a shared registered OR unit (s = A | B).
// Macro OR_ARB_FAIR_EN selects round-robin; otherwise fixed priority (req[0] highest).
module or_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  or_unit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [1:0]       winner_s;
  logic [1:0]       winner_r;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH-1:0] a_lat_r;
  logic [WIDTH-1:0] b_lat_r;
  logic [WIDTH-1:0] s_r;
  logic [1:0]       id_r;
  logic [3:0]       gnt_r;
  logic [3:0]       ack_r;
  logic             valid_r;
  logic             busy_r;

  function automatic logic [1:0] first_set(input logic [3:0] r);
    logic [1:0] idx;
    casez (r)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

`ifdef OR_ARB_FAIR_EN
  logic [1:0] ptr_r;
  logic [3:0] rot_s;

  // Round-robin winner: rotate req so the pointer slot is bit 0, then pick lowest.
  always_comb begin
    rot_s    = 4'({bus.req, bus.req} >> ptr_r);
    winner_s = ptr_r + first_set(rot_s);
  end

  // Priority pointer advances past each granted requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 2'd0;
    end else if ((state_r == IDLE) && (bus.req != 4'b0000)) begin
      ptr_r <= winner_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed-priority winner: lowest-numbered active request.
  always_comb begin
    winner_s = first_set(bus.req);
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; every non-IDLE state lasts one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          next_state_s = CAPTURE;
        end else begin
          next_state_s = IDLE;
        end
      end
      CAPTURE: next_state_s = EXEC;
      EXEC:    next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand slice of the current winner.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    case (winner_r)
      2'd0: begin
        a_sel_s = bus.a_bus[0*WIDTH +: WIDTH];
        b_sel_s = bus.b_bus[0*WIDTH +: WIDTH];
      end
      2'd1: begin
        a_sel_s = bus.a_bus[1*WIDTH +: WIDTH];
        b_sel_s = bus.b_bus[1*WIDTH +: WIDTH];
      end
      2'd2: begin
        a_sel_s = bus.a_bus[2*WIDTH +: WIDTH];
        b_sel_s = bus.b_bus[2*WIDTH +: WIDTH];
      end
      2'd3: begin
        a_sel_s = bus.a_bus[3*WIDTH +: WIDTH];
        b_sel_s = bus.b_bus[3*WIDTH +: WIDTH];
      end
      default: begin
        a_sel_s = '0;
        b_sel_s = '0;
      end
    endcase
  end

  // Datapath and registered outputs; each is set on the edge entering its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      winner_r <= 2'd0;
      a_lat_r  <= '0;
      b_lat_r  <= '0;
      s_r      <= '0;
      id_r     <= 2'd0;
      gnt_r    <= 4'b0000;
      ack_r    <= 4'b0000;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.req != 4'b0000) begin
            winner_r <= winner_s;
            gnt_r    <= onehot(winner_s);
          end else begin
            gnt_r    <= 4'b0000;
          end
        end
        CAPTURE: begin
          gnt_r   <= 4'b0000;
          a_lat_r <= a_sel_s;
          b_lat_r <= b_sel_s;
        end
        EXEC: begin
          s_r     <= a_lat_r | b_lat_r;
          id_r    <= winner_r;
          valid_r <= 1'b1;
          ack_r   <= onehot(winner_r);
        end
        DONE: begin
          valid_r <= 1'b0;
          ack_r   <= 4'b0000;
        end
        default: begin
          gnt_r   <= 4'b0000;
          valid_r <= 1'b0;
          ack_r   <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.s     = s_r;
  assign bus.id    = id_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;

endmodule
